// File: rtl/chess_pkg.sv
// Shared constants for the chess clock: FSM encodings, BCD digit limits and
// the packed mm:ss layout used by both sides' displays.
package chess_pkg;

  localparam int NIB_W = 4;

  localparam logic [NIB_W-1:0] DIGIT_MAX  = 4'd9;
  localparam logic [NIB_W-1:0] S_TENS_MAX = 4'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [NIB_W-1:0] m_tens;
    logic [NIB_W-1:0] m_units;
    logic [NIB_W-1:0] s_tens;
    logic [NIB_W-1:0] s_units;
  } mmss_t;

  // Builds the {m_tens, m_units, 0, 0} display word for a whole number of minutes.
  function automatic logic [4*NIB_W-1:0] mmss_load(input int minutes);
    return {NIB_W'(minutes / 10), NIB_W'(minutes % 10), {2*NIB_W{1'b0}}};
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD mm:ss word with zero detect on
// the result. A 00:00 input is held at 00:00 rather than wrapping.
module bcd_mmss_dec
  import chess_pkg::*;
(
  input  logic [4*NIB_W-1:0] time_in,
  output logic [4*NIB_W-1:0] time_out,
  output logic               dec_zero
);

  mmss_t cur;
  mmss_t nxt;

  assign cur = mmss_t'(time_in);

  always_comb begin
    nxt = cur;
    if (time_in != '0) begin
      if (cur.s_units != '0) begin
        nxt.s_units = cur.s_units - 4'd1;
      end else begin
        nxt.s_units = DIGIT_MAX;
        if (cur.s_tens != '0) begin
          nxt.s_tens = cur.s_tens - 4'd1;
        end else begin
          nxt.s_tens = S_TENS_MAX;
          if (cur.m_units != '0) begin
            nxt.m_units = cur.m_units - 4'd1;
          end else begin
            nxt.m_units = DIGIT_MAX;
            nxt.m_tens  = cur.m_tens - 4'd1;
          end
        end
      end
    end
  end

  assign time_out = nxt;
  assign dec_zero = (nxt == '0);

endmodule

// File: rtl/chess_clock.sv
// Two-sided chess clock: one-second prescaler, per-side BCD mm:ss countdown,
// pause/resume, and sticky flags when a side runs out of time.
module chess_clock
  import chess_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int START_MIN = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        move_done,
  input  logic        pause,
  output logic [15:0] time_w,
  output logic [15:0] time_b,
  output logic        turn,
  output logic        running,
  output logic        flag_w,
  output logic        flag_b
);

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [15:0]     LOAD_TIME = mmss_load(START_MIN);

  logic [1:0]    state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [15:0]   time_w_n, time_b_n;
  logic          turn_n, running_n, flag_w_n, flag_b_n;

  logic [15:0]   w_dec, b_dec;
  logic          w_zero, b_zero;
  logic          tick, expire;

  bcd_mmss_dec u_dec_w (
    .time_in  (time_w),
    .time_out (w_dec),
    .dec_zero (w_zero)
  );

  bcd_mmss_dec u_dec_b (
    .time_in  (time_b),
    .time_out (b_dec),
    .dec_zero (b_zero)
  );

  assign tick   = (state == ST_RUN) && (presc == PRESC_MAX);
  assign expire = tick && (turn ? b_zero : w_zero);

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    time_w_n = time_w;
    time_b_n = time_b;
    turn_n   = turn;
    flag_w_n = flag_w;
    flag_b_n = flag_b;
    case (state)
      ST_IDLE, ST_TIMEOUT: begin
        if (start) begin
          state_n  = ST_RUN;
          presc_n  = '0;
          time_w_n = LOAD_TIME;
          time_b_n = LOAD_TIME;
          turn_n   = 1'b0;
          flag_w_n = 1'b0;
          flag_b_n = 1'b0;
        end
      end
      ST_RUN: begin
        presc_n = tick ? '0 : presc + PW'(1);
        // The tick always charges the side that was moving, even when a
        // move_done or pause arrives in the same cycle.
        if (tick) begin
          if (!turn) time_w_n = w_dec;
          else       time_b_n = b_dec;
        end
        if (expire) begin
          state_n = ST_TIMEOUT;
          if (!turn) flag_w_n = 1'b1;
          else       flag_b_n = 1'b1;
        end else if (pause) begin
          state_n = ST_PAUSED;
          if (!tick) presc_n = presc;
        end else if (move_done) begin
          turn_n  = ~turn;
          presc_n = '0;
        end
      end
      ST_PAUSED: begin
        if (pause) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
    running_n = (state_n == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      presc   <= '0;
      time_w  <= LOAD_TIME;
      time_b  <= LOAD_TIME;
      turn    <= 1'b0;
      running <= 1'b0;
      flag_w  <= 1'b0;
      flag_b  <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      time_w  <= time_w_n;
      time_b  <= time_b_n;
      turn    <= turn_n;
      running <= running_n;
      flag_w  <= flag_w_n;
      flag_b  <= flag_b_n;
    end
  end

endmodule

// File: tb/tb_chess_clock.sv
// Directed plus randomized bench for chess_clock; expected values come from a
// seconds-based model of the game rules.
module tb_chess_clock;

  localparam int CLK_HZ    = 4;
  localparam int START_MIN = 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, move_done = 1'b0, pause = 1'b0;
  logic [15:0] time_w, time_b;
  logic        turn, running, flag_w, flag_b;

  logic        reset10_n = 1'b0, start10 = 1'b0, md10 = 1'b0, pz10 = 1'b0;
  logic [15:0] time10_w, time10_b;
  logic        turn10, running10, flag10_w, flag10_b;

  int total = 0;
  int bad   = 0;

  int m_state, m_presc, m_tw, m_tb, m_turn, m_fw, m_fb;

  chess_clock #(.CLK_HZ(CLK_HZ), .START_MIN(START_MIN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .move_done(move_done),
    .pause(pause), .time_w(time_w), .time_b(time_b), .turn(turn),
    .running(running), .flag_w(flag_w), .flag_b(flag_b)
  );

  chess_clock #(.CLK_HZ(CLK_HZ), .START_MIN(10)) dut10 (
    .clk(clk), .reset_n(reset10_n), .start(start10), .move_done(md10),
    .pause(pz10), .time_w(time10_w), .time_b(time10_b), .turn(turn10),
    .running(running10), .flag_w(flag10_w), .flag_b(flag10_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int sec);
    int m;
    int s;
    m = sec / 60;
    s = sec % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_presc = 0;
    m_tw    = START_MIN * 60;
    m_tb    = START_MIN * 60;
    m_turn  = 0;
    m_fw    = 0;
    m_fb    = 0;
  endtask

  task automatic model_step(input logic s, input logic m, input logic p);
    bit tick;
    bit expired;
    case (m_state)
      M_IDLE, M_TIMEOUT: begin
        if (s) begin
          m_tw = START_MIN * 60; m_tb = START_MIN * 60;
          m_turn = 0; m_presc = 0; m_fw = 0; m_fb = 0;
          m_state = M_RUN;
        end
      end
      M_RUN: begin
        tick = (m_presc == CLK_HZ - 1);
        expired = 0;
        if (tick) begin
          if (m_turn == 0) begin
            m_tw = m_tw - 1;
            if (m_tw == 0) begin m_fw = 1; expired = 1; end
          end else begin
            m_tb = m_tb - 1;
            if (m_tb == 0) begin m_fb = 1; expired = 1; end
          end
        end
        if (expired) begin
          m_state = M_TIMEOUT;
          m_presc = 0;
        end else if (p) begin
          m_state = M_PAUSED;
          if (tick) m_presc = 0;
        end else if (m) begin
          m_turn  = 1 - m_turn;
          m_presc = 0;
        end else begin
          m_presc = tick ? 0 : m_presc + 1;
        end
      end
      M_PAUSED: begin
        if (p) m_state = M_RUN;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic check_all(input string where);
    chk({where, "/time_w"},  time_w,  to_bcd(m_tw));
    chk({where, "/time_b"},  time_b,  to_bcd(m_tb));
    chk({where, "/turn"},    16'(turn),    16'(m_turn));
    chk({where, "/running"}, 16'(running), 16'(m_state == M_RUN));
    chk({where, "/flag_w"},  16'(flag_w),  16'(m_fw));
    chk({where, "/flag_b"},  16'(flag_b),  16'(m_fb));
  endtask

  task automatic step(input logic s, input logic m, input logic p);
    start = s; move_done = m; pause = p;
    @(posedge clk);
    model_step(s, m, p);
    #1;
    start = 1'b0; move_done = 1'b0; pause = 1'b0;
  endtask

  task automatic async_reset(input string where);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    chk({where, "/const_tw"}, time_w, 16'h0100);
    chk({where, "/const_run"}, 16'(running), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset/const_tw", time_w, 16'h0100);
    chk("reset/const_tb", time_b, 16'h0100);
    @(negedge clk);
    reset_n = 1'b1;
    reset10_n = 1'b1;

    // Idle ignores move_done/pause and never ticks
    step(0, 1, 0); step(0, 0, 1);
    repeat (6) step(0, 0, 0);
    check_all("idle");
    chk("idle/const_tw", time_w, 16'h0100);

    // Start, two ticks of White
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    check_all("run8");
    chk("run8/time_w", time_w, 16'h0058);
    chk("run8/time_b", time_b, 16'h0100);
    chk("run8/turn", 16'(turn), 16'h0);
    chk("run8/running", 16'(running), 16'h1);

    // move_done coinciding with tick
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    check_all("mdtick");
    chk("mdtick/time_w", time_w, 16'h0057);
    chk("mdtick/turn", 16'(turn), 16'h1);
    repeat (3) step(0, 0, 0);
    chk("btick3/time_b", time_b, 16'h0100);
    step(0, 0, 0);
    chk("btick4/time_b", time_b, 16'h0059);

    // Pause at prescaler 2, hold 20 cycles with stray move_done, resume
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1);
    chk("pause/running", 16'(running), 16'h0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1'($urandom_range(0, 1)), 0);
      check_all("paused");
    end
    chk("paused/time_b", time_b, 16'h0059);
    step(0, 0, 1);
    chk("resume/running", 16'(running), 16'h1);
    step(0, 0, 0);
    chk("resume1/time_b", time_b, 16'h0059);
    step(0, 0, 0);
    chk("resume2/time_b", time_b, 16'h0058);
    check_all("resume2");

    // Hand back to White and let White's time run out
    step(0, 1, 0);
    for (int i = 0; i < 400 && !flag_w; i++) step(0, 0, 0);
    check_all("timeout");
    chk("timeout/flag_w", 16'(flag_w), 16'h1);
    chk("timeout/time_w", time_w, 16'h0000);
    chk("timeout/running", 16'(running), 16'h0);
    step(0, 1, 0); step(0, 0, 1);
    repeat (6) step(0, 0, 0);
    check_all("timeout_hold");
    chk("hold/time_w", time_w, 16'h0000);
    chk("hold/time_b", time_b, 16'h0058);
    step(1, 0, 0);
    check_all("restart");
    chk("restart/flag_w", 16'(flag_w), 16'h0);
    chk("restart/time_w", time_w, 16'h0100);
    chk("restart/time_b", time_b, 16'h0100);

    // Asynchronous reset in the middle of RUN
    repeat (5) step(0, 0, 0);
    async_reset("midreset");

    // Random pulses against the model
    step(1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 100) == 0, ($urandom % 7) == 0, ($urandom % 13) == 0);
      check_all("rnd");
      if (($urandom % 400) == 0) async_reset("rnd_reset");
    end

    // START_MIN=10 borrow through every nibble
    @(negedge clk); start10 = 1'b1;
    @(negedge clk); start10 = 1'b0;
    repeat (3) @(negedge clk);
    chk("min10/pre_tw", time10_w, 16'h1000);
    @(negedge clk);
    chk("min10/time_w", time10_w, 16'h0959);
    chk("min10/time_b", time10_b, 16'h1000);
    chk("min10/running", 16'(running10), 16'h1);
    chk("min10/turn", 16'(turn10), 16'h0);
    chk("min10/flags", 16'({flag10_w, flag10_b}), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
